// File: rtl/gpu_pipe_pkg.sv
// Shared types and default widths for the Filter-GPU vector pipeline stages.
package gpu_pipe_pkg;

  typedef struct packed {
    logic pc_src;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_t;

  localparam int N_DEF     = 18;
  localparam int LANES_DEF = 3;
  localparam int AW_DEF    = 10;
  localparam int RW_DEF    = 4;
  localparam int CW_DEF    = 16;

endpackage

// File: rtl/ex_mem_stage_buf_if.sv
// Execute-to-memory bundle bus: upstream valid/ready in, downstream valid/ready out.
interface ex_mem_stage_buf_if #(
  parameter int N     = 18,
  parameter int LANES = 3,
  parameter int AW    = 10,
  parameter int RW    = 4,
  parameter int CW    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES-1:0][N-1:0]   alu_result;
  logic [AW-1:0]             mem_addr2;
  logic [AW-1:0]             mem_addr3;
  logic [LANES-1:0][N-1:0]   write_data;
  logic [RW-1:0]             wa3;
  logic                      pc_src;
  logic                      reg_write;
  logic                      mem_to_reg;
  logic                      mem_write;

  logic                      out_valid;
  logic                      out_ready;
  logic [LANES-1:0][N-1:0]   alu_result_o;
  logic [AW-1:0]             mem_addr2_o;
  logic [AW-1:0]             mem_addr3_o;
  logic [LANES-1:0][N-1:0]   write_data_o;
  logic [RW-1:0]             wa3_o;
  logic                      pc_src_o;
  logic                      reg_write_o;
  logic                      mem_to_reg_o;
  logic                      mem_write_o;
  logic [CW-1:0]             stall_count;

  modport master (
    output in_valid, alu_result, mem_addr2, mem_addr3, write_data, wa3,
           pc_src, reg_write, mem_to_reg, mem_write, out_ready,
    input  in_ready, out_valid, alu_result_o, mem_addr2_o, mem_addr3_o,
           write_data_o, wa3_o, pc_src_o, reg_write_o, mem_to_reg_o,
           mem_write_o, stall_count
  );

  modport slave (
    input  in_valid, alu_result, mem_addr2, mem_addr3, write_data, wa3,
           pc_src, reg_write, mem_to_reg, mem_write, out_ready,
    output in_ready, out_valid, alu_result_o, mem_addr2_o, mem_addr3_o,
           write_data_o, wa3_o, pc_src_o, reg_write_o, mem_to_reg_o,
           mem_write_o, stall_count
  );

endinterface

// File: rtl/stage_bundle_reg.sv
// One full execute-to-memory bundle held in a load-enabled register with synchronous clear.
module stage_bundle_reg
  import gpu_pipe_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF,
  parameter int AW    = AW_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    load,
  input  logic [LANES-1:0][N-1:0] alu_d,
  input  logic [LANES-1:0][N-1:0] wdata_d,
  input  logic [AW-1:0]           addr2_d,
  input  logic [AW-1:0]           addr3_d,
  input  logic [RW-1:0]           wa3_d,
  input  ctrl_t                   ctrl_d,
  output logic [LANES-1:0][N-1:0] alu_q,
  output logic [LANES-1:0][N-1:0] wdata_q,
  output logic [AW-1:0]           addr2_q,
  output logic [AW-1:0]           addr3_q,
  output logic [RW-1:0]           wa3_q,
  output ctrl_t                   ctrl_q
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      alu_q   <= '0;
      wdata_q <= '0;
      addr2_q <= '0;
      addr3_q <= '0;
      wa3_q   <= '0;
      ctrl_q  <= '0;
    end else if (load) begin
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      addr2_q <= addr2_d;
      addr3_q <= addr3_d;
      wa3_q   <= wa3_d;
      ctrl_q  <= ctrl_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage_buf.sv
// Execute-to-memory stage: 2-entry skid buffer with registered ready, flush and a
// saturating back-pressure counter.
module ex_mem_stage_buf
  import gpu_pipe_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF,
  parameter int AW    = AW_DEF,
  parameter int RW    = RW_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  ex_mem_stage_buf_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state;
  logic          out_valid_r;
  logic          in_ready_r;
  logic [CW-1:0] stall_r;

  logic accept, drain;
  logic load_main, load_skid, main_from_skid;

  ctrl_t                   in_ctrl, main_ctrl, skid_ctrl, main_ctrl_d;
  logic [LANES-1:0][N-1:0] main_alu, skid_alu, main_alu_d;
  logic [LANES-1:0][N-1:0] main_wd, skid_wd, main_wd_d;
  logic [AW-1:0]           main_a2, skid_a2, main_a2_d;
  logic [AW-1:0]           main_a3, skid_a3, main_a3_d;
  logic [RW-1:0]           main_wa3, skid_wa3, main_wa3_d;

  assign accept  = bus.in_valid & in_ready_r;
  assign drain   = out_valid_r & bus.out_ready;
  assign in_ctrl = '{pc_src: bus.pc_src, reg_write: bus.reg_write,
                     mem_to_reg: bus.mem_to_reg, mem_write: bus.mem_write};

  // Flush suppresses every load so nothing presented that cycle is captured.
  always_comb begin
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: load_main = accept;
        ONE: begin
          load_main = accept & drain;
          load_skid = accept & ~drain;
        end
        TWO: begin
          load_main      = drain;
          main_from_skid = drain;
        end
        default: ;
      endcase
    end
  end

  assign main_alu_d  = main_from_skid ? skid_alu  : bus.alu_result;
  assign main_wd_d   = main_from_skid ? skid_wd   : bus.write_data;
  assign main_a2_d   = main_from_skid ? skid_a2   : bus.mem_addr2;
  assign main_a3_d   = main_from_skid ? skid_a3   : bus.mem_addr3;
  assign main_wa3_d  = main_from_skid ? skid_wa3  : bus.wa3;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;

  stage_bundle_reg #(.N(N), .LANES(LANES), .AW(AW), .RW(RW)) u_main (
    .clk     (clk),
    .clear_n (reset),
    .load    (load_main),
    .alu_d   (main_alu_d),
    .wdata_d (main_wd_d),
    .addr2_d (main_a2_d),
    .addr3_d (main_a3_d),
    .wa3_d   (main_wa3_d),
    .ctrl_d  (main_ctrl_d),
    .alu_q   (main_alu),
    .wdata_q (main_wd),
    .addr2_q (main_a2),
    .addr3_q (main_a3),
    .wa3_q   (main_wa3),
    .ctrl_q  (main_ctrl)
  );

  stage_bundle_reg #(.N(N), .LANES(LANES), .AW(AW), .RW(RW)) u_skid (
    .clk     (clk),
    .clear_n (reset),
    .load    (load_skid),
    .alu_d   (bus.alu_result),
    .wdata_d (bus.write_data),
    .addr2_d (bus.mem_addr2),
    .addr3_d (bus.mem_addr3),
    .wa3_d   (bus.wa3),
    .ctrl_d  (in_ctrl),
    .alu_q   (skid_alu),
    .wdata_q (skid_wd),
    .addr2_q (skid_a2),
    .addr3_q (skid_a3),
    .wa3_q   (skid_wa3),
    .ctrl_q  (skid_ctrl)
  );

  // Occupancy FSM; the stall counter samples the pre-flush out_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      stall_r     <= '0;
    end else begin
      if (out_valid_r && !bus.out_ready && (stall_r != {CW{1'b1}}))
        stall_r <= stall_r + 1'b1;
      if (flush) begin
        state       <= EMPTY;
        out_valid_r <= 1'b0;
        in_ready_r  <= 1'b1;
      end else begin
        case (state)
          EMPTY: if (accept) begin
            state       <= ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
          ONE: begin
            if (accept && !drain) begin
              state       <= TWO;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else if (!accept && drain) begin
              state       <= EMPTY;
              out_valid_r <= 1'b0;
              in_ready_r  <= 1'b1;
            end
          end
          TWO: if (drain) begin
            state       <= ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
          default: begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.stall_count  = stall_r;
  assign bus.alu_result_o = main_alu;
  assign bus.write_data_o = main_wd;
  assign bus.mem_addr2_o  = main_a2;
  assign bus.mem_addr3_o  = main_a3;
  assign bus.wa3_o        = main_wa3;
  assign bus.pc_src_o     = out_valid_r & main_ctrl.pc_src;
  assign bus.reg_write_o  = out_valid_r & main_ctrl.reg_write;
  assign bus.mem_to_reg_o = out_valid_r & main_ctrl.mem_to_reg;
  assign bus.mem_write_o  = out_valid_r & main_ctrl.mem_write;

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Scoreboard bench for ex_mem_stage_buf: a queue models the skid buffer contents.
module tb_ex_mem_stage_buf;
  localparam int N = 18, LANES = 3, AW = 10, RW = 4, CW = 4;
  localparam int DW = LANES * N;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [RW-1:0] wa3;
    logic [3:0]    ctrl;
  } bundle_t;

  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  ex_mem_stage_buf_if #(.N(N), .LANES(LANES), .AW(AW), .RW(RW), .CW(CW)) bus ();
  ex_mem_stage_buf #(.N(N), .LANES(LANES), .AW(AW), .RW(RW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  bundle_t sb[$];
  int      checks = 0;
  int      errors = 0;
  int      exp_stall = 0;
  bit      last_acc;
  bundle_t cur_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bundle_t b, input logic v);
    cur_b              = b;
    bus.in_valid       = v;
    bus.alu_result     = b.alu;
    bus.write_data     = b.wd;
    bus.mem_addr2      = b.a2;
    bus.mem_addr3      = b.a3;
    bus.wa3            = b.wa3;
    bus.pc_src         = b.ctrl[3];
    bus.reg_write      = b.ctrl[2];
    bus.mem_to_reg     = b.ctrl[1];
    bus.mem_write      = b.ctrl[0];
  endtask

  function automatic bundle_t rnd(input logic [RW-1:0] wa);
    bundle_t     b;
    logic [63:0] t;
    t = {$urandom(), $urandom()}; b.alu = t[DW-1:0];
    t = {$urandom(), $urandom()}; b.wd  = t[DW-1:0];
    t = {$urandom(), $urandom()};
    b.a2   = t[AW-1:0];
    b.a3   = t[AW+19:20];
    b.ctrl = t[43:40];
    b.wa3  = wa;
    return b;
  endfunction

  // Check DUT against the model at the negedge, then advance the model across the edge.
  task automatic tick();
    bit acc, drn;
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
    chk("stall_count", 64'(bus.stall_count), 64'(exp_stall));
    if (sb.size() != 0) begin
      chk("alu_result_o", 64'(bus.alu_result_o), 64'(sb[0].alu));
      chk("write_data_o", 64'(bus.write_data_o), 64'(sb[0].wd));
      chk("mem_addr2_o", 64'(bus.mem_addr2_o), 64'(sb[0].a2));
      chk("mem_addr3_o", 64'(bus.mem_addr3_o), 64'(sb[0].a3));
      chk("wa3_o", 64'(bus.wa3_o), 64'(sb[0].wa3));
      chk("ctrl_o", 64'({bus.pc_src_o, bus.reg_write_o, bus.mem_to_reg_o, bus.mem_write_o}),
          64'(sb[0].ctrl));
    end else begin
      chk("ctrl_idle", 64'({bus.pc_src_o, bus.reg_write_o, bus.mem_to_reg_o, bus.mem_write_o}),
          64'(0));
    end
    last_acc = 1'b0;
    if (!reset) begin
      sb.delete();
      exp_stall = 0;
    end else begin
      if (sb.size() != 0 && !bus.out_ready && exp_stall != (1 << CW) - 1) exp_stall++;
      if (flush) sb.delete();
      else begin
        acc = bus.in_valid && (sb.size() < 2);
        drn = (sb.size() != 0) && bus.out_ready;
        if (drn) void'(sb.pop_front());
        if (acc) sb.push_back(cur_b);
        last_acc = acc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_data(input string tag);
    chk({tag, "_alu"}, 64'(bus.alu_result_o), 64'(0));
    chk({tag, "_wd"}, 64'(bus.write_data_o), 64'(0));
    chk({tag, "_addr"}, 64'({bus.mem_addr2_o, bus.mem_addr3_o, bus.wa3_o}), 64'(0));
  endtask

  bundle_t idle_b, a_b;
  int saved_stall;

  initial begin
    idle_b = '0;
    reset  = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    drive(idle_b, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_zero_data("reset");
    tick();

    // Single pass
    a_b      = '0;
    a_b.alu  = {18'h3FFFF, 18'h00001, 18'h12345};
    a_b.a2   = 10'h3A5;
    a_b.wa3  = 4'hC;
    a_b.ctrl = 4'b0100;
    bus.out_ready = 1'b1;
    drive(a_b, 1'b1);
    tick();
    drive(idle_b, 1'b0);
    repeat (2) tick();

    // Back-pressure: A, B into the buffer, C held upstream
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rnd(RW'(i + 1)), 1'b1);
      tick();
    end
    repeat (2) tick();
    chk("stall_bp", 64'(bus.stall_count), 64'(4));
    bus.out_ready = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    chk("c_accepted", 64'(last_acc), 64'(1));
    drive(idle_b, 1'b0);
    repeat (3) tick();

    // Streaming
    saved_stall = exp_stall;
    for (int i = 0; i < 20; i++) begin
      drive(rnd(RW'(i)), 1'b1);
      tick();
    end
    drive(idle_b, 1'b0);
    repeat (2) tick();
    chk("stall_stream", 64'(bus.stall_count), 64'(saved_stall));

    // Flush while two bundles are held and D is presented
    bus.out_ready = 1'b0;
    drive(rnd(4'h1), 1'b1); tick();
    drive(rnd(4'h2), 1'b1); tick();
    drive(rnd(4'hD), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(idle_b, 1'b0);
    chk("flush_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Saturation, then reset beats flush
    bus.out_ready = 1'b0;
    drive(rnd(4'h7), 1'b1); tick();
    drive(idle_b, 1'b0);
    repeat (20) tick();
    chk("stall_sat", 64'(bus.stall_count), 64'(15));
    flush = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    flush = 1'b0;
    chk("rst_stall", 64'(bus.stall_count), 64'(0));
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk_zero_data("rst_mid");
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
